sys_array_feeder: RTL and testbench

SYS_ARRAY_FEEDER -- requirements
Module: sys_array_feeder

---
 rtl/sys_array_feeder.sv | 185 ++++++++++++++++++
 tb/tb_sys_array_feeder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_feeder.sv
// Skewed matrix feeder for a systolic array: it captures the weights and the data matrix, then streams the data diagonally.
// Define SYS_FEEDER_LANE_VALID_EN to add the per-lane lane_valid output.
module sys_array_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int ARRAY_W_W    = 4,
    parameter int ARRAY_W_L    = 4,
    parameter int ARRAY_A_W    = 4,
    parameter int ARRAY_A_L    = 4,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic                                                start,
    input  logic [ARRAY_W_W-1:0][ARRAY_W_L-1:0][DATA_WIDTH-1:0] weight_in,
    input  logic [ARRAY_A_W-1:0][ARRAY_A_L-1:0][DATA_WIDTH-1:0] matrix_in,
    output logic                                                busy,
    output logic                                                done,
    output logic                                                weights_load,
    output logic [ARRAY_W_W-1:0][ARRAY_W_L-1:0][DATA_WIDTH-1:0] weight_data,
    output logic [ARRAY_A_W-1:0][DATA_WIDTH-1:0]                input_data
`ifdef SYS_FEEDER_LANE_VALID_EN
    ,
    output logic [0:ARRAY_A_W-1]                                lane_valid
`endif
);

    localparam int FEED_CYCLES = ARRAY_A_L + ARRAY_A_W - 1;
    localparam int FCW = (FEED_CYCLES > 1) ? $clog2(FEED_CYCLES) : 1;
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                                                state_q;
    logic [FCW-1:0]                                        feed_cnt_q;
    logic [DCW-1:0]                                        drain_cnt_q;
    logic [ARRAY_A_W-1:0][ARRAY_A_L-1:0][DATA_WIDTH-1:0]   matrix_q;
    logic [ARRAY_W_W-1:0][ARRAY_W_L-1:0][DATA_WIDTH-1:0]   weight_q;
    logic                                                  busy_q;
    logic                                                  done_q;
    logic                                                  weights_load_q;
    logic [ARRAY_A_W-1:0][DATA_WIDTH-1:0]                  lanes_q;

    logic [ARRAY_A_W-1:0][DATA_WIDTH-1:0]                  skew_d;
    int                                                    feed_idx_d;
    logic                                                  feed_last;
    logic                                                  drain_last;
    logic                                                  feeding_d;

    assign feed_last  = (int'(feed_cnt_q) == FEED_CYCLES - 1);
    assign drain_last = (int'(drain_cnt_q) == DRAIN_CYCLES - 1);

    // Column index of the FEED cycle that the next edge enters, and whether that edge enters FEED at all.
    always_comb begin
        feed_idx_d = 0;
        feeding_d  = 1'b0;
        if (state_q == LOAD) begin
            feed_idx_d = 0;
            feeding_d  = 1'b1;
        end else if (state_q == FEED && !feed_last) begin
            feed_idx_d = int'(feed_cnt_q) + 1;
            feeding_d  = 1'b1;
        end
    end

    // Lane r carries column (c - r) of row r, so each row is delayed by one cycle relative to the row above it.
    generate
        for (genvar gi = 0; gi < ARRAY_A_W; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] lane_val;
            always_comb begin
                lane_val = '0;
                for (int col = 0; col < ARRAY_A_L; col++) begin
                    if (feed_idx_d == gi + col) begin
                        lane_val = matrix_q[gi][col];
                    end
                end
            end
            assign skew_d[gi] = lane_val;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            feed_cnt_q     <= '0;
            drain_cnt_q    <= '0;
            matrix_q       <= '0;
            weight_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            weights_load_q <= 1'b0;
            lanes_q        <= '0;
        end else begin
            weights_load_q <= 1'b0;
            done_q         <= 1'b0;
            lanes_q        <= feeding_d ? skew_d : '0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        matrix_q       <= matrix_in;
                        weight_q       <= weight_in;
                        state_q        <= LOAD;
                        busy_q         <= 1'b1;
                        weights_load_q <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q    <= FEED;
                    feed_cnt_q <= '0;
                end
                FEED: begin
                    if (feed_last) begin
                        if (DRAIN_CYCLES == 0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= DRAIN;
                            drain_cnt_q <= '0;
                        end
                    end else begin
                        feed_cnt_q <= feed_cnt_q + FCW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DCW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign weights_load = weights_load_q;
    assign weight_data  = weight_q;
    assign input_data   = lanes_q;

`ifdef SYS_FEEDER_LANE_VALID_EN
    logic [0:ARRAY_A_W-1] skew_vld_d;
    logic [0:ARRAY_A_W-1] lane_valid_q;

    generate
        for (genvar gi = 0; gi < ARRAY_A_W; gi++) begin : g_vld
            logic lane_vld;
            always_comb begin
                lane_vld = 1'b0;
                for (int col = 0; col < ARRAY_A_L; col++) begin
                    if (feed_idx_d == gi + col) begin
                        lane_vld = 1'b1;
                    end
                end
            end
            assign skew_vld_d[gi] = lane_vld;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_valid_q <= '0;
        end else begin
            lane_valid_q <= feeding_d ? skew_vld_d : '0;
        end
    end

    assign lane_valid = lane_valid_q;
`endif

endmodule

// File: tb/tb_sys_array_feeder.sv
// Bench for sys_array_feeder: directed and random runs, with start held high, a mid-run reset, and input changes during a run.
module tb_sys_array_feeder;

    typedef logic [3:0][3:0][7:0] mat_t;
    typedef logic [3:0][7:0]      lanes_t;

    logic   clk = 1'b0;
    logic   reset_n;
    logic   start;
    mat_t   weight_in;
    mat_t   matrix_in;
    logic   busy;
    logic   done;
    logic   weights_load;
    mat_t   weight_data;
    lanes_t input_data;
`ifdef SYS_FEEDER_LANE_VALID_EN
    logic [0:3] lane_valid;
`endif

    int vectors    = 0;
    int miscompares = 0;

    sys_array_feeder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .weight_in    (weight_in),
        .matrix_in    (matrix_in),
        .busy         (busy),
        .done         (done),
        .weights_load (weights_load),
        .weight_data  (weight_data),
        .input_data   (input_data)
`ifdef SYS_FEEDER_LANE_VALID_EN
        ,
        .lane_valid   (lane_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic mat_t rand_mat();
        mat_t m;
        m = {$urandom(), $urandom(), $urandom(), $urandom()};
        return m;
    endfunction

    // Cycle k of a run counts from the accepting edge: k=0 LOAD, k=1..7 FEED (c=k-1), k=8..15 DRAIN, k=16 DONE.
    function automatic lanes_t exp_lanes(input mat_t a, input int k);
        lanes_t l;
        int c;
        l = '0;
        c = k - 1;
        if (k >= 1 && k <= 7) begin
            for (int r = 0; r < 4; r++) begin
                if (c - r >= 0 && c - r < 4) l[r] = a[r][c-r];
            end
        end
        return l;
    endfunction

    function automatic logic [0:3] exp_valid(input int k);
        logic [0:3] v;
        int c;
        v = '0;
        c = k - 1;
        if (k >= 1 && k <= 7) begin
            for (int r = 0; r < 4; r++) begin
                if (c - r >= 0 && c - r < 4) v[r] = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic check_run(input mat_t a, input mat_t w, input bit directed, input bit hold,
                             input mat_t na, input mat_t nw);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            chk($sformatf("busy k=%0d", k), busy, 1'b1);
            chk($sformatf("weights_load k=%0d", k), weights_load, (k == 0));
            chk($sformatf("done k=%0d", k), done, (k == 16));
            chk($sformatf("input_data k=%0d", k), input_data, exp_lanes(a, k));
            chk($sformatf("weight_data k=%0d", k), weight_data, w);
`ifdef SYS_FEEDER_LANE_VALID_EN
            chk($sformatf("lane_valid k=%0d", k), lane_valid, exp_valid(k));
            if (directed && k == 2) chk("lane_valid c1", lane_valid, 4'b1100);
`endif
            if (directed && k == 1) chk("lanes c0", input_data, 32'h00000001);
            if (directed && k == 4) chk("lanes c3", input_data, 32'h0D0A0704);
            if (directed && k == 7) chk("lanes c6", input_data, 32'h10000000);
            if (k == 16) begin
                matrix_in = na;
                weight_in = nw;
                start     = hold;
            end else begin
                matrix_in = rand_mat();
                weight_in = rand_mat();
                start     = hold ? 1'b1 : ((k % 5) == 2);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " done"}, done, 1'b0);
        chk({tag, " weights_load"}, weights_load, 1'b0);
        chk({tag, " input_data"}, input_data, '0);
    endtask

    initial begin
        mat_t a;
        mat_t w;
        mat_t a2;
        mat_t w2;

        reset_n   = 1'b1;
        start     = 1'b0;
        matrix_in = '0;
        weight_in = '0;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset weights_load", weights_load, 1'b0);
        chk("reset input_data", input_data, '0);
        chk("reset weight_data", weight_data, '0);
        reset_n = 1'b1;

        // Directed matrix A[r][c] = 4r+c+1
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                a[r][c] = 8'(4 * r + c + 1);
        w = rand_mat();
        @(negedge clk);
        matrix_in = a;
        weight_in = w;
        start     = 1'b1;
        check_run(a, w, 1'b1, 1'b0, '0, '0);
        check_idle("post directed");

        for (int n = 0; n < 3; n++) begin
            a = rand_mat();
            w = rand_mat();
            matrix_in = a;
            weight_in = w;
            start     = 1'b1;
            check_run(a, w, 1'b0, 1'b0, '0, '0);
            check_idle($sformatf("post random %0d", n));
        end

        // Start held high across a whole run: the next run begins only after one IDLE cycle
        a  = rand_mat();
        w  = rand_mat();
        a2 = rand_mat();
        w2 = rand_mat();
        matrix_in = a;
        weight_in = w;
        start     = 1'b1;
        check_run(a, w, 1'b0, 1'b1, a2, w2);
        check_idle("held start gap");
        check_run(a2, w2, 1'b0, 1'b0, '0, '0);
        check_idle("post held");

        // Reset during FEED c=3
        a = rand_mat();
        w = rand_mat();
        matrix_in = a;
        weight_in = w;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset lanes c3", input_data, exp_lanes(a, 4));
        reset_n = 1'b0;
        #1;
        chk("async reset busy", busy, 1'b0);
        chk("async reset done", done, 1'b0);
        chk("async reset weights_load", weights_load, 1'b0);
        chk("async reset input_data", input_data, '0);
        chk("async reset weight_data", weight_data, '0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("no resume busy %0d", i), busy, 1'b0);
            chk($sformatf("no resume done %0d", i), done, 1'b0);
        end

        // First start after reset is accepted
        a = rand_mat();
        w = rand_mat();
        matrix_in = a;
        weight_in = w;
        start     = 1'b1;
        check_run(a, w, 1'b0, 1'b0, '0, '0);
        check_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
